// File: rtl/prim_rom_scanner.sv
// prim_rom_scanner: ROM integrity scanner with host read pass-through.
// Folds every ROM word into a rotate-XOR checksum and checks it against a golden value.

module prim_rom_scanner #(
    parameter int Width         = 32,
    parameter int Depth         = 2048,
    parameter int Aw            = $clog2(Depth),
    parameter int TimeoutCycles = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [Width-1:0] expected_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             err_timeout_o,
    output logic [Width-1:0] checksum_o,
    output logic [Aw-1:0]    rom_addr_o,
    output logic             rom_cs_o,
    input  logic [Width-1:0] rom_dout_i,
    input  logic             rom_dvalid_i,
    input  logic             host_req_i,
    input  logic [Aw-1:0]    host_addr_i,
    output logic             host_gnt_o,
    output logic             host_rvalid_o,
    output logic [Width-1:0] host_rdata_o
);

    localparam int CntW = $clog2(TimeoutCycles + 1);
    localparam logic [Aw-1:0]   LastAddr = Aw'(Depth - 1);
    localparam logic [CntW-1:0] CntLast  = CntW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StCheck
    } state_e;

    state_e           state_q, state_d;
    logic [Aw-1:0]    addr_q, addr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [Width-1:0] sum_q, sum_d;
    logic             pass_q, pass_d;
    logic             err_q, err_d;
    logic             hpend_q, hpend_d;

    // State, scan address, timeout counter, checksum and sticky result registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            pass_q  <= 1'b0;
            err_q   <= 1'b0;
            hpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            hpend_q <= hpend_d;
        end
    end

    // Next state plus the ROM strobe and host handshake; one ROM read in flight at most
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        sum_d         = sum_q;
        pass_d        = pass_q;
        err_d         = err_q;
        hpend_d       = hpend_q;
        done_o        = 1'b0;
        rom_cs_o      = 1'b0;
        rom_addr_o    = addr_q;
        host_gnt_o    = 1'b0;
        host_rvalid_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (hpend_q) begin
                    host_rvalid_o = rom_dvalid_i;
                    if (rom_dvalid_i) begin
                        hpend_d = 1'b0;
                    end
                end else if (start_i) begin
                    sum_d   = '0;
                    pass_d  = 1'b0;
                    err_d   = 1'b0;
                    addr_d  = '0;
                    state_d = StReq;
                end else if (host_req_i && !rst_i) begin
                    host_gnt_o = 1'b1;
                    rom_cs_o   = 1'b1;
                    rom_addr_o = host_addr_i;
                    hpend_d    = 1'b1;
                end
            end
            StReq: begin
                rom_cs_o = 1'b1;
                cnt_d    = '0;
                state_d  = StWait;
            end
            StWait: begin
                if (rom_dvalid_i) begin
                    sum_d = {sum_q[Width-2:0], sum_q[Width-1]} ^ rom_dout_i;
                    if (addr_q == LastAddr) begin
                        state_d = StCheck;
                    end else begin
                        addr_d  = addr_q + Aw'(1);
                        state_d = StReq;
                    end
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    pass_d  = 1'b0;
                    done_o  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StCheck: begin
                pass_d  = (sum_q == expected_i);
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy_o        = (state_q != StIdle);
    assign pass_o        = pass_q;
    assign err_timeout_o = err_q;
    assign checksum_o    = sum_q;
    assign host_rdata_o  = rom_dout_i;

endmodule

// File: tb/tb_prim_rom_scanner.sv
// tb_prim_rom_scanner: directed bench with a cycle-timeline reference model.
// A 1-cycle ROM model answers reads and can withhold data at one address.

module tb_prim_rom_scanner;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int A  = 2;
    localparam int TO = 15;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [W-1:0] expected_i;
    logic         busy_o;
    logic         done_o;
    logic         pass_o;
    logic         err_timeout_o;
    logic [W-1:0] checksum_o;
    logic [A-1:0] rom_addr_o;
    logic         rom_cs_o;
    logic [W-1:0] rom_dout_i;
    logic         rom_dvalid_i;
    logic         host_req_i;
    logic [A-1:0] host_addr_i;
    logic         host_gnt_o;
    logic         host_rvalid_o;
    logic [W-1:0] host_rdata_o;

    prim_rom_scanner #(
        .Width(W),
        .Depth(D),
        .Aw(A),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .start_i(start_i),
        .expected_i(expected_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .pass_o(pass_o),
        .err_timeout_o(err_timeout_o),
        .checksum_o(checksum_o),
        .rom_addr_o(rom_addr_o),
        .rom_cs_o(rom_cs_o),
        .rom_dout_i(rom_dout_i),
        .rom_dvalid_i(rom_dvalid_i),
        .host_req_i(host_req_i),
        .host_addr_i(host_addr_i),
        .host_gnt_o(host_gnt_o),
        .host_rvalid_o(host_rvalid_o),
        .host_rdata_o(host_rdata_o)
    );

    always #5 clk_i = ~clk_i;

    logic [W-1:0] mem [D] = '{8'h01, 8'h02, 8'h03, 8'h04};
    int           wh_addr = -1;
    logic         dv_q;
    logic [W-1:0] dq;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dv_q <= 1'b0;
            dq   <= '0;
        end else begin
            dv_q <= rom_cs_o && (int'(rom_addr_o) != wh_addr);
            dq   <= mem[rom_addr_o];
        end
    end

    assign rom_dvalid_i = dv_q;
    assign rom_dout_i   = dq;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    bit           scanning = 0;
    int           s = 0;
    int           wh_m = -1;
    int           kmax = 0;
    int           ncap = 0;
    int           e_end = 0;
    bit           m_pass = 0;
    bit           m_err = 0;
    logic [W-1:0] m_sum = '0;
    int           host_g = -10;
    logic [A-1:0] host_a = '0;
    int           last_done = -1;
    int           done_cnt = 0;
    int           cs_cnt = 0;
    int           gnt_cnt = 0;
    logic [W-1:0] last_rdata = '0;
    int           t0 = 0;

    function automatic logic [W-1:0] fold(int n);
        logic [W-1:0] c;
        c = '0;
        for (int i = 0; i < n; i++) begin
            c = {c[W-2:0], c[W-1]} ^ mem[i];
        end
        return c;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        bit           e_busy, e_done, e_cs, e_gnt, e_rv, e_pass, e_err;
        bit           newscan, pend;
        logic [A-1:0] e_addr;
        logic [W-1:0] e_sum, e_rdata;
        int           r, n;
        @(negedge clk_i);
        e_busy  = 0;
        e_done  = 0;
        e_cs    = 0;
        e_gnt   = 0;
        e_rv    = 0;
        e_addr  = '0;
        e_rdata = '0;
        e_sum   = m_sum;
        e_pass  = m_pass;
        e_err   = m_err;
        newscan = 0;
        r       = 0;
        n       = 0;
        if (rst_i) begin
            scanning = 0;
            host_g   = -10;
            m_pass   = 0;
            m_err    = 0;
            m_sum    = '0;
            e_sum    = '0;
            e_pass   = 0;
            e_err    = 0;
        end else begin
            if (scanning) begin
                r      = cyc - s;
                e_busy = 1;
                e_pass = 0;
                e_err  = 0;
                e_done = (r == e_end);
                if ((r % 2) == 1 && (r - 1) / 2 <= kmax) begin
                    e_cs   = 1;
                    e_addr = A'((r - 1) / 2);
                end
                n = (r >= 3) ? (r - 1) / 2 : 0;
                if (n > ncap) n = ncap;
                e_sum = fold(n);
            end
            pend = (host_g == cyc - 1);
            if (pend) begin
                e_rv    = 1;
                e_rdata = mem[host_a];
            end
            if (!scanning && !pend && start_i) begin
                newscan = 1;
            end else if (!scanning && !pend && host_req_i) begin
                e_gnt  = 1;
                e_cs   = 1;
                e_addr = host_addr_i;
                host_g = cyc;
                host_a = host_addr_i;
            end
        end
        chk("busy", busy_o, e_busy);
        chk("done", done_o, e_done);
        chk("rom_cs", rom_cs_o, e_cs);
        chk("host_gnt", host_gnt_o, e_gnt);
        chk("host_rvalid", host_rvalid_o, e_rv);
        chk("pass", pass_o, e_pass);
        chk("err_timeout", err_timeout_o, e_err);
        chk("checksum", checksum_o, e_sum);
        if (e_cs || rst_i) chk("rom_addr", rom_addr_o, e_addr);
        if (e_rv) chk("host_rdata", host_rdata_o, e_rdata);
        if (!rst_i && scanning && r == e_end) begin
            m_pass   = (wh_m < 0) && (fold(D) == expected_i);
            m_err    = (wh_m >= 0);
            m_sum    = fold(n);
            scanning = 0;
        end
        if (newscan) begin
            scanning = 1;
            s        = cyc;
            wh_m     = wh_addr;
            kmax     = (wh_m >= 0) ? wh_m : D - 1;
            ncap     = (wh_m >= 0) ? wh_m : D;
            e_end    = (wh_m >= 0) ? 2 * wh_m + 1 + TO : 2 * D + 1;
        end
        if (done_o) begin
            last_done = cyc;
            done_cnt++;
        end
        if (rom_cs_o) cs_cnt++;
        if (host_gnt_o) gnt_cnt++;
        if (host_rvalid_o) last_rdata = host_rdata_o;
        cyc++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_scan(int cycles);
        t0      = cyc;
        cs_cnt  = 0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (cycles) step();
    endtask

    initial begin
        rst_i       = 1'b1;
        start_i     = 1'b0;
        expected_i  = 8'h02;
        host_req_i  = 1'b0;
        host_addr_i = '0;
        repeat (2) step();
        rst_i = 1'b0;
        step();

        run_scan(12);
        chk("pass_done_at", last_done - t0, 9);
        chk("pass_cs_pulses", cs_cnt, 4);
        chk("pass_checksum", checksum_o, 8'h02);
        chk("pass_flag", pass_o, 1);

        expected_i = 8'h05;
        run_scan(12);
        chk("fail_done_at", last_done - t0, 9);
        chk("fail_flag", pass_o, 0);
        chk("fail_no_timeout", err_timeout_o, 0);
        chk("fail_checksum", checksum_o, 8'h02);
        expected_i = 8'h02;

        wh_addr = 2;
        run_scan(24);
        chk("to_done_at", last_done - t0, 20);
        chk("to_err", err_timeout_o, 1);
        chk("to_pass", pass_o, 0);
        chk("to_busy", busy_o, 0);
        wh_addr = -1;

        gnt_cnt     = 0;
        host_req_i  = 1'b1;
        host_addr_i = 2'd3;
        step();
        host_req_i = 1'b0;
        step();
        chk("host_gnt_cnt", gnt_cnt, 1);
        chk("host_data", last_rdata, 8'h04);

        host_req_i  = 1'b1;
        host_addr_i = 2'd1;
        start_i     = 1'b1;
        step();
        start_i    = 1'b0;
        host_req_i = 1'b0;
        chk("start_beats_host", busy_o, 1);
        chk("start_no_gnt", gnt_cnt, 1);
        repeat (11) step();

        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (4) step();
        rst_i = 1'b1;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_cs", rom_cs_o, 0);
        repeat (2) step();
        rst_i = 1'b0;
        step();
        run_scan(12);
        chk("post_rst_checksum", checksum_o, 8'h02);
        chk("post_rst_pass", pass_o, 1);

        done_cnt = 0;
        start_i  = 1'b1;
        repeat (12) step();
        start_i = 1'b0;
        repeat (10) step();
        chk("held_start_scans", done_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
